// File: rtl/filtro_pkg.sv
// Shared definitions for the filter UART receiver: FSM encoding and oversampling constants.
package filtro_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator: one-clk s_tick every BAUD_DIV clocks.
module baud_tick_gen #(
    parameter int unsigned BAUD_DIV = 326
) (
    input  logic clk,
    input  logic reset,
    output logic s_tick
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign s_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_filtro.sv
// 8N1 UART receiver at 16x oversampling; emits one-clk done / framing-error pulses.
module uart_rx_filtro
    import filtro_pkg::*;
#(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned BAUD_DIV = 326
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            framing_err,
    output logic            busy
);

    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [3:0]    S_MID  = 4'(MID_TICK);
    localparam logic [3:0]    S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            w_s_tick;
    logic            r_sync1;
    logic            r_rx_s;
    state_t          r_state;
    logic [3:0]      r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_ferr;

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .s_tick (w_s_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= START;
                        r_s     <= '0;
                    end
                end
                START: begin
                    if (w_s_tick) begin
                        if (r_s == S_MID) begin
                            if (!r_rx_s) begin
                                r_state <= DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_s_tick) begin
                        if (r_s == S_LAST) begin
                            r_s <= '0;
                            r_b <= {r_rx_s, r_b[DBIT-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_s_tick) begin
                        if (r_s == S_STOP) begin
                            r_s <= '0;
                            if (r_rx_s) begin
                                r_dout  <= r_b;
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= BREAK;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // r_s marks "line high since the previous tick"; any low sample re-arms the wait
                    if (!r_rx_s) begin
                        r_s <= '0;
                    end else if (w_s_tick) begin
                        if (r_s != '0) begin
                            r_state <= IDLE;
                            r_s     <= '0;
                        end else begin
                            r_s <= 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_done_tick = r_done;
    assign framing_err  = r_ferr;
    assign dout         = r_dout;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_filtro.sv
// Directed bench for uart_rx_filtro: frame-level expectation queue plus per-cycle invariant checks.
module tb_uart_rx_filtro;

    localparam int BAUD_DIV = 4;
    localparam int CPB      = BAUD_DIV * 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       framing_err;
    logic       busy;

    uart_rx_filtro #(
        .DBIT     (8),
        .SB_TICK  (16),
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .framing_err  (framing_err),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       ev;
    int         ev_lat;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_done = 0;
    int         n_err = 0;
    bit         rst_at_edge = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] model_dout = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    // Outputs are sampled on the falling edge, half a period after any update.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            model_dout = 8'h00;
            check("reset_done", rx_done_tick, 0);
            check("reset_ferr", framing_err, 0);
            check("reset_busy", busy, 0);
            check("reset_dout", dout, 0);
        end else begin
            if (rx_done_tick || framing_err) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got done=%0b ferr=%0b, expected none",
                             rx_done_tick, framing_err);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", framing_err, ev.is_err);
                    if (!ev.is_err) model_dout = ev.data;
                    ev_lat = cyc - ev.start_cyc;
                    check("latency_window", (ev_lat >= 9 * CPB && ev_lat <= 11 * CPB), 1);
                end
            end
            if (rx_done_tick) n_done++;
            if (framing_err) n_err++;
            check("done_twice", rx_done_tick && prev_done, 0);
            check("done_and_ferr", rx_done_tick && framing_err, 0);
            check("dout_model", dout, model_dout);
        end
        prev_done = rx_done_tick;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        exp_t e;
        e.is_err    = !stop_bit;
        e.data      = d;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d5a;
        d5a = 8'h5A;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(CPB);
        check("init_dout", dout, 8'h00);
        check("init_busy", busy, 0);

        // 1: valid 0xA5
        send_byte(8'hA5, 1'b1);
        idle(CPB / 2);
        wait_drain("t1_drain");
        check("t1_dout", dout, 8'hA5);
        check("t1_done_cnt", n_done, 1);
        check("t1_ferr_cnt", n_err, 0);
        check("t1_busy", busy, 0);

        // 2: short low glitch is rejected in START
        rx = 1'b0;
        repeat (3 * BAUD_DIV) @(negedge clk);
        rx = 1'b1;
        check("t2_busy_start", busy, 1);
        idle(2 * CPB);
        check("t2_busy", busy, 0);
        check("t2_done_cnt", n_done, 1);
        check("t2_ferr_cnt", n_err, 0);
        check("t2_dout", dout, 8'hA5);

        // 3: bad stop bit then a long break
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40 * BAUD_DIV) @(negedge clk);
        check("t3_busy_break", busy, 1);
        check("t3_ferr_cnt", n_err, 1);
        check("t3_done_cnt", n_done, 1);
        check("t3_dout_kept", dout, 8'hA5);
        idle(2 * CPB);
        check("t3_busy_after", busy, 0);
        wait_drain("t3_drain_err");
        send_byte(8'h11, 1'b1);
        idle(CPB / 2);
        wait_drain("t3_drain");
        check("t3_dout", dout, 8'h11);
        check("t3_done_cnt2", n_done, 2);

        // 4: back-to-back frames with no idle gap
        send_byte(8'h00, 1'b1);
        check("t4_first", dout, 8'h00);
        send_byte(8'hFF, 1'b1);
        idle(CPB / 2);
        wait_drain("t4_drain");
        check("t4_dout", dout, 8'hFF);
        check("t4_done_cnt", n_done, 4);

        // 5: reset during bit 4 of 0x5A, then the full frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d5a[i]);
        rx = d5a[4];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        check("t5_busy_rst", busy, 0);
        check("t5_dout_rst", dout, 8'h00);
        idle(3 * CPB);
        check("t5_busy", busy, 0);
        check("t5_dout", dout, 8'h00);
        check("t5_done_cnt", n_done, 4);
        check("t5_ferr_cnt", n_err, 1);
        send_byte(8'h5A, 1'b1);
        idle(CPB / 2);
        wait_drain("t5_drain");
        check("t5_dout2", dout, 8'h5A);
        check("t5_done_cnt2", n_done, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion, expected finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
